// File: rtl/sd_cmd_serdes.sv
// SD CMD-line bit engine: serialises a 40-bit command with CRC7 and end bit,
// then captures, CRC-checks and hands upstream the card response.
module sd_cmd_serdes #(
  parameter int unsigned NCR_MAX    = 64,
  parameter int unsigned NCC_CYCLES = 8
) (
  input  logic         iClock_SD_Host,
  input  logic         iReset,
  input  logic         iStrobe_cmd,
  input  logic [39:0]  iCmd_frame,
  input  logic         iResp_none,
  input  logic         iResp_long,
  input  logic         iResp_check_crc,
  input  logic         iAck_resp,
  output logic         oSerial_ready,
  output logic         oAck_cmd,
  output logic         oStrobe_resp,
  output logic [135:0] oResponse,
  output logic         oTimeout,
  output logic         oCrc_error,
  output logic         oCmd_oe,
  output logic         oCmd_bit,
  input  logic         iCmd_pin
);

  localparam int unsigned WAIT_W = $clog2(NCR_MAX + 1);
  localparam int unsigned NCC_W  = $clog2(NCC_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_START, RECV, RESP, NCC} state_t;
  state_t state, stateNext;

  logic [39:0]       txShift;
  logic [6:0]        txCrc;
  logic [5:0]        sendCnt;
  logic              respNone, respLong, checkCrc;
  logic [WAIT_W-1:0] waitCnt;
  logic [7:0]        rxCnt;
  logic [6:0]        rxCrc;
  logic [135:0]      rxShift;
  logic [NCC_W-1:0]  nccCnt;
  logic              timeoutFlag, crcErrFlag, ackPulse;

  logic sendDone, rxLast, waitExpired, nccDone, inWindow;

  function automatic logic [6:0] crc7Step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign sendDone    = (sendCnt == 6'd47);
  assign rxLast      = (rxCnt == (respLong ? 8'd135 : 8'd47));
  assign waitExpired = (waitCnt == WAIT_W'(NCR_MAX));
  assign nccDone     = (nccCnt == NCC_W'(NCC_CYCLES - 1));
  // CRC covers everything between the header and the CRC field itself
  assign inWindow    = respLong ? (rxCnt >= 8'd8 && rxCnt <= 8'd127)
                                : (rxCnt >= 8'd1 && rxCnt <= 8'd39);

  always_ff @(posedge iClock_SD_Host or negedge iReset) begin
    if (!iReset) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:       if (iStrobe_cmd) stateNext = SEND;
      SEND:       if (sendDone) stateNext = respNone ? NCC : WAIT_START;
      WAIT_START: begin
        if (!iCmd_pin)        stateNext = RECV;
        else if (waitExpired) stateNext = RESP;
      end
      RECV:       if (rxLast) stateNext = RESP;
      RESP:       if (iAck_resp) stateNext = NCC;
      NCC:        if (nccDone) stateNext = IDLE;
      default:    stateNext = IDLE;
    endcase
  end

  always_comb begin
    oSerial_ready = (state == IDLE);
    oCmd_oe       = (state == SEND);
    oStrobe_resp  = (state == RESP);
    oCmd_bit      = 1'b1;
    if (state == SEND) begin
      if (sendCnt < 6'd40)      oCmd_bit = txShift[39];
      else if (sendCnt < 6'd47) oCmd_bit = txCrc[6];
    end
  end

  always_ff @(posedge iClock_SD_Host or negedge iReset) begin
    if (!iReset) begin
      txShift     <= '0;
      txCrc       <= '0;
      sendCnt     <= '0;
      respNone    <= 1'b0;
      respLong    <= 1'b0;
      checkCrc    <= 1'b0;
      waitCnt     <= '0;
      rxCnt       <= '0;
      rxCrc       <= '0;
      rxShift     <= '0;
      nccCnt      <= '0;
      timeoutFlag <= 1'b0;
      crcErrFlag  <= 1'b0;
      ackPulse    <= 1'b0;
    end else begin
      ackPulse <= 1'b0;
      case (state)
        IDLE: if (iStrobe_cmd) begin
          txShift  <= iCmd_frame;
          respNone <= iResp_none;
          respLong <= iResp_long;
          checkCrc <= iResp_check_crc;
          txCrc    <= '0;
          sendCnt  <= '0;
          rxShift  <= '0;
          rxCrc    <= '0;
          rxCnt    <= '0;
          ackPulse <= 1'b1;
        end
        SEND: begin
          sendCnt <= sendCnt + 6'd1;
          if (sendCnt < 6'd40) begin
            txCrc   <= crc7Step(txCrc, txShift[39]);
            txShift <= {txShift[38:0], 1'b0};
          end else begin
            txCrc <= {txCrc[5:0], 1'b0};
          end
          if (sendDone) begin
            waitCnt <= WAIT_W'(1);
            nccCnt  <= '0;
          end
        end
        WAIT_START: begin
          waitCnt <= waitCnt + WAIT_W'(1);
          if (!iCmd_pin) begin
            rxShift <= {rxShift[134:0], iCmd_pin};
            rxCnt   <= 8'd1;
          end else if (waitExpired) begin
            timeoutFlag <= 1'b1;
          end
        end
        RECV: begin
          rxShift <= {rxShift[134:0], iCmd_pin};
          rxCnt   <= rxCnt + 8'd1;
          if (inWindow) rxCrc <= crc7Step(rxCrc, iCmd_pin);
          // On the last bit the received CRC field sits in rxShift[6:0]
          if (rxLast) begin
            if (respLong) crcErrFlag <= (rxCrc != rxShift[6:0]);
            else          crcErrFlag <= (checkCrc && (rxCrc != rxShift[6:0])) || !iCmd_pin;
          end
        end
        RESP: if (iAck_resp) nccCnt <= '0;
        NCC: begin
          nccCnt <= nccCnt + NCC_W'(1);
          if (nccDone) begin
            timeoutFlag <= 1'b0;
            crcErrFlag  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign oAck_cmd   = ackPulse;
  assign oResponse  = rxShift;
  assign oTimeout   = timeoutFlag;
  assign oCrc_error = crcErrFlag;

endmodule
